// File: rtl/mul8x1_mux_if.sv
// Bus bundle for the 8-to-1 selector: eight data inputs, select address,
// combinational and registered selected outputs.
interface mul8x1_mux_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] D0;
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] D2;
  logic [WIDTH-1:0] D3;
  logic [WIDTH-1:0] D4;
  logic [WIDTH-1:0] D5;
  logic [WIDTH-1:0] D6;
  logic [WIDTH-1:0] D7;
  logic [2:0]       addr;
  logic [WIDTH-1:0] F;
  logic [WIDTH-1:0] F_q;

  modport master (
    output D0, D1, D2, D3, D4, D5, D6, D7, addr,
    input  F, F_q
  );

  modport slave (
    input  D0, D1, D2, D3, D4, D5, D6, D7, addr,
    output F, F_q
  );
endinterface

// File: rtl/mul8x1_mux.sv
// One-of-eight data selector with a zero-latency output F and a registered
// copy F_q that clears asynchronously on rst.
module mul8x1_mux #(
  parameter int WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  mul8x1_mux_if.slave   bus
);

  logic [WIDTH-1:0] f_d;
  logic [WIDTH-1:0] f_q;

  // Unknown select falls to the default branch so F never propagates X.
  always_comb begin
    f_d = '0;
    case (bus.addr)
      3'b000:  f_d = bus.D0;
      3'b001:  f_d = bus.D1;
      3'b010:  f_d = bus.D2;
      3'b011:  f_d = bus.D3;
      3'b100:  f_d = bus.D4;
      3'b101:  f_d = bus.D5;
      3'b110:  f_d = bus.D6;
      3'b111:  f_d = bus.D7;
      default: f_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q <= '0;
    end else begin
      f_q <= f_d;
    end
  end

  assign bus.F   = f_d;
  assign bus.F_q = f_q;

endmodule

// File: tb/tb_mul8x1_mux.sv
// Directed bench for mul8x1_mux: literal checks at each step plus a per-cycle
// comparison against an indexing model of F and a one-cycle-delayed model of F_q.
module tb_mul8x1_mux;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic [2:0] addr;
  logic       m_fq;
  logic       cmp_on;
  int         tests;
  int         fails;

  mul8x1_mux_if #(.WIDTH(1)) bus ();

  assign bus.D0   = d[0];
  assign bus.D1   = d[1];
  assign bus.D2   = d[2];
  assign bus.D3   = d[3];
  assign bus.D4   = d[4];
  assign bus.D5   = d[5];
  assign bus.D6   = d[6];
  assign bus.D7   = d[7];
  assign bus.addr = addr;

  mul8x1_mux #(.WIDTH(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic sel(input logic [7:0] dv, input logic [2:0] a);
    return dv[a];
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got=%0b expected=%0b", name, $time, act, exp);
    end
  endtask

  // Reference register: whatever was selected at the last rising edge, zero under reset.
  always @(posedge clk or posedge rst) begin
    if (rst) m_fq = 1'b0;
    else     m_fq = sel(d, addr);
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_F", bus.F, sel(d, addr));
      check("model_F_q", bus.F_q, m_fq);
    end
  end

  initial begin
    logic [2:0] walk [8];
    logic       exp_a5 [8];
    walk   = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    exp_a5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tests  = 0;
    fails  = 0;
    cmp_on = 1'b0;
    m_fq   = 1'b0;
    rst    = 1'b1;
    d      = 8'h00;
    addr   = 3'd0;

    #2;
    check("reset_F_q", bus.F_q, 1'b0);
    #10;
    check("reset_hold_F_q", bus.F_q, 1'b0);
    cmp_on = 1'b1;
    rst    = 1'b0;
    #10;

    // Walk all addresses, pulsing only the selected input.
    for (int i = 0; i < 8; i++) begin
      addr = walk[i];
      d    = 8'h00;
      #1 check("walk_lo0", bus.F, 1'b0);
      #9;
      d[walk[i]] = 1'b1;
      #1 check("walk_hi", bus.F, 1'b1);
      #9;
      d[walk[i]] = 1'b0;
      #1 check("walk_lo1", bus.F, 1'b0);
      #9;
    end

    // Non-selected inputs must not leak through.
    addr = 3'b010;
    d    = 8'hFB;
    #1 check("iso_d2_0", bus.F, 1'b0);
    #9;
    d = 8'hFF;
    #1 check("iso_d2_1", bus.F, 1'b1);
    #9;
    d = 8'h04;
    #1 check("iso_others_0", bus.F, 1'b1);
    #9;

    // Static pattern, sweep address.
    d = 8'hA5;
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      #1 check($sformatf("sweep_a5_%0d", a), bus.F, exp_a5[a]);
      #9;
    end

    // Registered path out of reset.
    d    = 8'h00;
    addr = 3'd0;
    rst  = 1'b1;
    #1 check("rst_F_q", bus.F_q, 1'b0);
    #19;
    check("rst_hold_F_q", bus.F_q, 1'b0);
    rst  = 1'b0;
    addr = 3'b111;
    d    = 8'h80;
    #1 check("reg_F_now", bus.F, 1'b1);
    check("reg_F_q_before_edge", bus.F_q, 1'b0);
    #4;
    check("reg_F_q_after_edge", bus.F_q, 1'b1);
    #5;

    // Async reset between edges.
    rst = 1'b1;
    #1 check("async_F_q", bus.F_q, 1'b0);
    check("async_F", bus.F, 1'b1);
    #9;
    rst = 1'b0;
    #1 check("rel_F_q_before_edge", bus.F_q, 1'b0);
    #4;
    check("rel_F_q_after_edge", bus.F_q, 1'b1);
    #5;

    // Registered path tracks a changing selection one edge late.
    d = 8'h7F;
    #1 check("reg_F_drop", bus.F, 1'b0);
    check("reg_F_q_lag", bus.F_q, 1'b1);
    #4;
    check("reg_F_q_follow", bus.F_q, 1'b0);
    #25;

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
